// File: rtl/dallanma_cozucu_blogu.sv
// ============================================================================
// dallanma_cozucu_blogu : execute-stage branch resolver, prediction FIFO + flush
// Rev 1.0
// ============================================================================
`default_nettype none

module dallanma_cozucu_blogu #(
    parameter int DERINLIK        = 4,
    parameter int BOSALTMA_CEVRIM = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ongoru_gecerli_i,
    input  logic [31:0] ongoru_ps_i,
    input  logic [31:0] ongoru_hedef_i,
    input  logic        cozum_gecerli_i,
    input  logic        cozum_atladi_i,
    input  logic [31:0] cozum_hedef_i,
    output logic        fifo_dolu_o,
    output logic        fifo_bos_o,
    output logic        guncelle_gecerli_o,
    output logic        guncelle_atladi_o,
    output logic [31:0] guncelle_ps_o,
    output logic [31:0] guncelle_hedef_adresi_o,
    output logic        dallanma_hata_o,
    output logic [31:0] duzeltilmis_ps_o,
    output logic        bosalt_o,
    output logic [31:0] hata_sayisi_o,
    output logic [31:0] cozum_sayisi_o
);

    localparam int AW = (DERINLIK > 1) ? $clog2(DERINLIK) : 1;
    localparam int SW = (BOSALTMA_CEVRIM > 1) ? $clog2(BOSALTMA_CEVRIM) : 1;
    localparam logic [AW:0]   C_DOLU_SAYI = (AW+1)'(DERINLIK);
    localparam logic [SW-1:0] C_SAYAC_YUK = SW'(BOSALTMA_CEVRIM - 1);

    localparam logic [0:0] NORMAL = 1'b0;
    localparam logic [0:0] BOSALT = 1'b1;

    logic [31:0]   mem_ps_q    [DERINLIK];
    logic [31:0]   mem_hedef_q [DERINLIK];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [0:0]    state_q, state_d;
    logic [SW-1:0] sayac_q, sayac_d;
    logic          dolu_q, dolu_d, bos_q, bos_d;
    logic          upd_q, upd_d, upd_atladi_q, upd_atladi_d, hata_q, hata_d;
    logic [31:0]   upd_ps_q, upd_ps_d, upd_hedef_q, upd_hedef_d, duz_ps_q, duz_ps_d;
    logic [31:0]   hata_say_q, hata_say_d, cozum_say_q, cozum_say_d;

    logic        w_normal, w_push, w_pop, w_hata;
    logic [31:0] w_gercek_ps;

    always_comb begin
        w_normal    = (state_q == NORMAL);
        w_pop       = cozum_gecerli_i && w_normal && (count_q != '0);
        w_push      = ongoru_gecerli_i && w_normal && ((count_q != C_DOLU_SAYI) || w_pop);
        w_gercek_ps = cozum_atladi_i ? cozum_hedef_i : (mem_ps_q[rd_ptr_q] + 32'd4);
        w_hata      = w_pop && (w_gercek_ps != mem_hedef_q[rd_ptr_q]);
    end

    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        state_d      = state_q;
        sayac_d      = sayac_q;
        upd_d        = w_pop;
        hata_d       = w_hata;
        upd_atladi_d = upd_atladi_q;
        upd_ps_d     = upd_ps_q;
        upd_hedef_d  = upd_hedef_q;
        duz_ps_d     = duz_ps_q;
        hata_say_d   = hata_say_q;
        cozum_say_d  = cozum_say_q;

        if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (w_push && !w_pop)      count_d = count_q + 1'b1;
        else if (w_pop && !w_push) count_d = count_q - 1'b1;

        if (w_pop) begin
            upd_atladi_d = cozum_atladi_i;
            upd_ps_d     = mem_ps_q[rd_ptr_q];
            upd_hedef_d  = cozum_hedef_i;
            if (cozum_say_q != 32'hFFFF_FFFF) cozum_say_d = cozum_say_q + 32'd1;
        end

        // Everything younger than a mispredicted branch is wrong-path, so drop it all.
        if (w_hata) begin
            duz_ps_d = w_gercek_ps;
            if (hata_say_q != 32'hFFFF_FFFF) hata_say_d = hata_say_q + 32'd1;
            state_d  = BOSALT;
            sayac_d  = C_SAYAC_YUK;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end

        if (state_q == BOSALT) begin
            if (sayac_q == '0) state_d = NORMAL;
            else               sayac_d = sayac_q - 1'b1;
        end

        dolu_d = (count_d == C_DOLU_SAYI);
        bos_d  = (count_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= NORMAL;
            sayac_q      <= '0;
            dolu_q       <= 1'b0;
            bos_q        <= 1'b1;
            upd_q        <= 1'b0;
            upd_atladi_q <= 1'b0;
            upd_ps_q     <= '0;
            upd_hedef_q  <= '0;
            hata_q       <= 1'b0;
            duz_ps_q     <= '0;
            hata_say_q   <= '0;
            cozum_say_q  <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            sayac_q      <= sayac_d;
            dolu_q       <= dolu_d;
            bos_q        <= bos_d;
            upd_q        <= upd_d;
            upd_atladi_q <= upd_atladi_d;
            upd_ps_q     <= upd_ps_d;
            upd_hedef_q  <= upd_hedef_d;
            hata_q       <= hata_d;
            duz_ps_q     <= duz_ps_d;
            hata_say_q   <= hata_say_d;
            cozum_say_q  <= cozum_say_d;
        end
    end

    // Storage needs no reset: an entry is only read after being written.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_ps_q[wr_ptr_q]    <= ongoru_ps_i;
            mem_hedef_q[wr_ptr_q] <= ongoru_hedef_i;
        end
    end

    assign fifo_dolu_o             = dolu_q;
    assign fifo_bos_o              = bos_q;
    assign guncelle_gecerli_o      = upd_q;
    assign guncelle_atladi_o       = upd_atladi_q;
    assign guncelle_ps_o           = upd_ps_q;
    assign guncelle_hedef_adresi_o = upd_hedef_q;
    assign dallanma_hata_o         = hata_q;
    assign duzeltilmis_ps_o        = duz_ps_q;
    assign bosalt_o                = (state_q == BOSALT);
    assign hata_sayisi_o           = hata_say_q;
    assign cozum_sayisi_o          = cozum_say_q;

endmodule

`default_nettype wire

// File: doc/dallanma_cozucu_blogu.md
Name: dallanma_cozucu_blogu

Overview:
- Execute-stage branch resolver; it is the consumer end of the fetch-stage bimodal predictor interface.
- Queues every prediction issued by fetch in an in-order FIFO and matches each entry against the actual outcome from the ALU.
- Drives the predictor update bus (guncelle_*) and misprediction recovery: a redirect PC plus a timed pipeline flush.
- Keeps misprediction and resolution counters for performance analysis.

Parameters:
- DERINLIK, 4, in-flight prediction FIFO depth; power of two, at least 2.
- BOSALTMA_CEVRIM, 2, number of cycles bosalt_o stays high after a misprediction; at least 1.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- ongoru_gecerli_i  input  1  fetch issued a prediction for a branch (push).
- ongoru_ps_i  input  32  PC of the predicted branch.
- ongoru_hedef_i  input  32  predicted next PC (target, or ps+4).
- cozum_gecerli_i  input  1  ALU resolved the oldest in-flight branch (pop).
- cozum_atladi_i  input  1  resolved branch was taken.
- cozum_hedef_i  input  32  actual taken target.
- fifo_dolu_o  output  1  FIFO full; fetch must stall branch issue.
- fifo_bos_o  output  1  FIFO empty.
- guncelle_gecerli_o  output  1  predictor update strobe.
- guncelle_atladi_o  output  1  outcome for the predictor.
- guncelle_ps_o  output  32  PC of the resolved branch.
- guncelle_hedef_adresi_o  output  32  actual target (cozum_hedef_i).
- dallanma_hata_o  output  1  single-cycle misprediction pulse.
- duzeltilmis_ps_o  output  32  corrected fetch PC; valid while dallanma_hata_o is high.
- bosalt_o  output  1  pipeline flush (wrong-path squash).
- hata_sayisi_o  output  32  misprediction count.
- cozum_sayisi_o  output  32  resolved-branch count.

Behaviour:
- Reset (rst_i high at an edge):
  - FIFO emptied (read and write pointers plus count cleared), FSM set to NORMAL.
  - All outputs 0, except fifo_bos_o=1.
  - Both counters set to 0.
  - Reset wins over every other input, including mid-flush; the flush is abandoned.
- FIFO:
  - Each entry holds {ps, predicted next PC}.
  - Push when ongoru_gecerli_i && state==NORMAL && (!dolu || accepted pop this cycle).
  - Pop when cozum_gecerli_i && state==NORMAL && !bos.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo DERINLIK.
  - A push while full with no pop is dropped, and fetch is at fault.
  - fifo_dolu_o and fifo_bos_o are registered, derived from the count.
- Resolution, computed combinationally on the head entry in cycle N:
  - gercek_ps = cozum_atladi_i ? cozum_hedef_i : head.ps + 4, with the add modulo 2^32.
  - hata = (gercek_ps != head.ongoru_hedef). This covers both a wrong direction and a wrong target.
- Outputs registered at edge N+1 (one-cycle latency):
  - guncelle_gecerli_o=1; guncelle_atladi_o, guncelle_ps_o and guncelle_hedef_adresi_o from cycle N.
  - cozum_sayisi_o increments.
  - If hata: dallanma_hata_o=1, duzeltilmis_ps_o=gercek_ps, hata_sayisi_o increments.
  - guncelle_gecerli_o and dallanma_hata_o are single-cycle pulses.
- Resolve while empty: ignored. No update, counters unchanged.
- FSM states:
  - NORMAL: push and pop accepted. On a pop with hata, go to BOSALT at edge N+1 and flush the whole FIFO at that edge, because younger entries, including a push accepted in cycle N, are wrong-path.
  - BOSALT: bosalt_o=1; all pushes and resolves ignored. A down-counter loaded with BOSALTMA_CEVRIM-1 decrements each cycle. When it reaches 0, return to NORMAL; bosalt_o is 0 from the next cycle.
- Counters saturate at 32'hFFFF_FFFF and never wrap.

Test Plan:
- Correct not-taken: push ps=0x100, hedef=0x104; resolve atladi=0 -> next cycle guncelle_gecerli_o=1, guncelle_ps_o=0x100, guncelle_atladi_o=0, dallanma_hata_o=0, cozum_sayisi_o=1, hata_sayisi_o=0.
- Direction mispredict: push ps=0x200, hedef=0x204; resolve atladi=1, hedef=0x400 -> dallanma_hata_o=1 for 1 cycle, duzeltilmis_ps_o=0x400, guncelle_hedef_adresi_o=0x400, bosalt_o=1 for exactly 2 cycles, fifo_bos_o=1, hata_sayisi_o=1.
- Target mispredict: push ps=0x300, hedef=0x500; resolve atladi=1, hedef=0x600 -> hata pulse with duzeltilmis_ps_o=0x600.
- FIFO full and order: 4 pushes (0x10, 0x20, 0x30, 0x40) -> fifo_dolu_o=1. A 5th push alone is dropped. A push of 0x50 simultaneous with a correct resolve is accepted. The next 4 resolves report ps 0x20, 0x30, 0x40, 0x50 in that order.
- Flush blocking and empty resolve: during BOSALT, a push and a resolve produce no update and the count stays 0. A resolve while empty in NORMAL -> no guncelle_gecerli_o.
- Reset mid-flush: assert rst_i in the 1st BOSALT cycle -> next cycle bosalt_o=0, fifo_bos_o=1, both counters 0. A push is accepted the following cycle.
